// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg: shared FSM state encoding, completion status codes and channel field widths
package pll_cfg_pkg;
    localparam int W_CH    = 3;
    localparam int W_RATIO = 10;
    localparam int W_DUTY  = 10;
    localparam int W_PHASE = 13;
    typedef enum logic [2:0] {S_IDLE, S_RST_ASSERT, S_WAIT_LOCK, S_DONE, S_FAIL} state_t;
    typedef enum logic [1:0] {ST_OK = 2'd0, ST_BAD = 2'd1, ST_LOCK_FAIL = 2'd2} status_t;
endpackage

// File: rtl/pll_lock_filt.sv
// pll_lock_filt: 2-flop synchroniser followed by a consecutive-sample lock filter
//   clk, rst : clock, asynchronous active-high reset
//   pll_lock : raw asynchronous lock from the PLL
//   locked   : toggles only after LOCK_FILT consecutive synchronised samples disagree with it
module pll_lock_filt #(
    parameter int LOCK_FILT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_lock,
    output logic locked
);
    localparam int FW = $clog2(LOCK_FILT + 1);
    logic          r_s1, r_s2, r_lk;
    logic [FW-1:0] r_cnt;
    logic          w_flip;
    assign w_flip = (r_s2 != r_lk) && (r_cnt == FW'(LOCK_FILT - 1));
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_lk  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1  <= pll_lock;
            r_s2  <= r_s1;
            // any sample agreeing with the current state restarts the run
            r_cnt <= (r_s2 == r_lk || w_flip) ? '0 : r_cnt + 1'b1;
            r_lk  <= r_lk ^ w_flip;
        end
    assign locked = r_lk;
endmodule

// File: rtl/pll_dyn_cfg.sv
// pll_dyn_cfg: dynamic PLL output-channel reconfiguration with reset/lock sequencing and retries
//   cfg_valid/cfg_ready/cfg_ch/cfg_ratio/cfg_duty/cfg_phase : request handshake and fields
//   cfg_done/cfg_status : one-cycle completion pulse and its status
//   pll_lock/pll_rst    : raw lock in, PLL reset out
//   dyn_odiv/dyn_duty/dyn_phase : per-channel settings, channel k in slice k
//   locked/busy/lock_lost/err_clr : filtered lock, FSM activity, sticky loss flag and its clear
module pll_dyn_cfg import pll_cfg_pkg::*; #(
    parameter int N_CH         = 5,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_FILT    = 8,
    parameter int MAX_RETRY    = 3,
    parameter int DEF_RATIO    = 6,
    parameter int DEF_DUTY     = 6,
    parameter int DEF_PHASE    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [W_CH-1:0]           cfg_ch,
    input  logic [W_RATIO-1:0]        cfg_ratio,
    input  logic [W_DUTY-1:0]         cfg_duty,
    input  logic [W_PHASE-1:0]        cfg_phase,
    output logic                      cfg_done,
    output logic [1:0]                cfg_status,
    input  logic                      pll_lock,
    output logic                      pll_rst,
    output logic [N_CH*W_RATIO-1:0]   dyn_odiv,
    output logic [N_CH*W_DUTY-1:0]    dyn_duty,
    output logic [N_CH*W_PHASE-1:0]   dyn_phase,
    output logic                      locked,
    output logic                      busy,
    output logic                      lock_lost,
    input  logic                      err_clr
);
    localparam int CMAX = LOCK_TIMEOUT > RST_CYCLES ? LOCK_TIMEOUT : RST_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int RW   = $clog2(MAX_RETRY + 2);
    state_t                   r_state, w_next;
    status_t                  r_status;
    logic [CW-1:0]            r_cnt;
    logic [RW-1:0]            r_retry;
    logic                     r_report, r_lk_d, r_lost;
    logic [N_CH*W_RATIO-1:0]  r_odiv;
    logic [N_CH*W_DUTY-1:0]   r_duty;
    logic [N_CH*W_PHASE-1:0]  r_phase;
    logic                     w_locked, w_acc, w_bad, w_loss, w_rise, w_tmo;
    pll_lock_filt #(.LOCK_FILT(LOCK_FILT)) u_filt (
        .clk      (clk),
        .rst      (rst),
        .pll_lock (pll_lock),
        .locked   (w_locked)
    );
    assign w_rise    = w_locked && !r_lk_d;
    assign w_loss    = (r_state == S_IDLE) && !w_locked && r_lk_d;
    // a lock loss wins the IDLE cycle, so a simultaneous request is held off rather than dropped
    assign cfg_ready = (r_state == S_IDLE) && !w_loss;
    assign w_acc     = cfg_valid && cfg_ready;
    assign w_bad     = (int'(cfg_ch) >= N_CH) || (cfg_ratio == '0);
    assign w_tmo     = r_cnt == CW'(LOCK_TIMEOUT - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= S_RST_ASSERT;
        else     r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       w_next = w_loss ? S_RST_ASSERT : !w_acc ? S_IDLE : w_bad ? S_DONE : S_RST_ASSERT;
            S_RST_ASSERT: w_next = (r_cnt == CW'(RST_CYCLES - 1)) ? S_WAIT_LOCK : S_RST_ASSERT;
            S_WAIT_LOCK:  w_next = w_rise ? S_DONE : !w_tmo ? S_WAIT_LOCK :
                                   (r_retry == RW'(MAX_RETRY)) ? S_FAIL : S_RST_ASSERT;
            default:      w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_cnt    <= '0;
            r_retry  <= '0;
            r_report <= 1'b0;
            r_status <= ST_OK;
            r_lk_d   <= 1'b0;
            r_lost   <= 1'b0;
            r_odiv   <= {N_CH{W_RATIO'(DEF_RATIO)}};
            r_duty   <= {N_CH{W_DUTY'(DEF_DUTY)}};
            r_phase  <= {N_CH{W_PHASE'(DEF_PHASE)}};
        end else begin
            // one counter times both the reset pulse and the lock wait; every state change restarts it
            r_cnt    <= (w_next != r_state || r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
            r_retry  <= (r_state == S_IDLE) ? '0 :
                        (r_state == S_WAIT_LOCK && w_next == S_RST_ASSERT) ? r_retry + 1'b1 : r_retry;
            r_lk_d   <= w_locked;
            r_lost   <= w_loss || (r_lost && !err_clr);
            // only request-driven sequences report; power-up and autonomous relocks stay silent
            r_report <= w_acc || (r_report && !w_loss);
            if (w_acc) r_status <= w_bad ? ST_BAD : ST_OK;
            for (int k = 0; k < N_CH; k++)
                if (w_acc && !w_bad && int'(cfg_ch) == k) begin
                    r_odiv[k*W_RATIO +: W_RATIO]  <= cfg_ratio;
                    r_duty[k*W_DUTY +: W_DUTY]    <= cfg_duty;
                    r_phase[k*W_PHASE +: W_PHASE] <= cfg_phase;
                end
        end
    assign cfg_done   = r_report && (r_state == S_DONE || r_state == S_FAIL);
    assign cfg_status = !cfg_done ? ST_OK : (r_state == S_FAIL) ? ST_LOCK_FAIL : r_status;
    assign pll_rst    = r_state == S_RST_ASSERT;
    assign busy       = r_state != S_IDLE;
    assign locked     = w_locked;
    assign lock_lost  = r_lost;
    assign dyn_odiv   = r_odiv;
    assign dyn_duty   = r_duty;
    assign dyn_phase  = r_phase;
endmodule

// File: tb/tb_pll_dyn_cfg.sv
// tb_pll_dyn_cfg: table-driven and scenario bench for pll_dyn_cfg with a PLL lock model and done scoreboard
module tb_pll_dyn_cfg;
    import pll_cfg_pkg::*;
    localparam int N_CH = 5, RST_CYCLES = 16, LOCK_TIMEOUT = 300, LOCK_FILT = 8, MAX_RETRY = 3;
    localparam int DR = 6, DD = 6, DP = 16, LOCK_DLY = 100, NV = 7;
    logic clk = 0, rst = 1, cfg_valid = 0, pll_lock = 0, err_clr = 0;
    logic [2:0] cfg_ch = 0;
    logic [9:0] cfg_ratio = 0, cfg_duty = 0;
    logic [12:0] cfg_phase = 0;
    logic cfg_ready, cfg_done, pll_rst, locked, busy, lock_lost;
    logic [1:0] cfg_status;
    logic [N_CH*10-1:0] dyn_odiv, dyn_duty;
    logic [N_CH*13-1:0] dyn_phase;
    pll_dyn_cfg #(.N_CH(N_CH), .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
                  .LOCK_FILT(LOCK_FILT), .MAX_RETRY(MAX_RETRY), .DEF_RATIO(DR),
                  .DEF_DUTY(DD), .DEF_PHASE(DP)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_ratio(cfg_ratio), .cfg_duty(cfg_duty), .cfg_phase(cfg_phase), .cfg_done(cfg_done),
        .cfg_status(cfg_status), .pll_lock(pll_lock), .pll_rst(pll_rst), .dyn_odiv(dyn_odiv),
        .dyn_duty(dyn_duty), .dyn_phase(dyn_phase), .locked(locked), .busy(busy),
        .lock_lost(lock_lost), .err_clr(err_clr)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [1:0] st;
        logic [N_CH*10-1:0] od, du;
        logic [N_CH*13-1:0] ph;
    } exp_t;
    typedef struct {
        logic [2:0] ch;
        logic [9:0] r, d;
        logic [12:0] p;
        bit lk;
        logic [1:0] st;
        int pulses;
    } vec_t;
    exp_t sb[$];
    vec_t tv[NV];
    int pq[$], gq[$];
    int checks = 0, errors = 0;
    bit mdl_on = 1, glitch = 0;
    int mcnt = 0;
    logic [N_CH*10-1:0] m_odiv, m_duty;
    logic [N_CH*13-1:0] m_phase;
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic m_reset();
        m_odiv  = {N_CH{10'(DR)}};
        m_duty  = {N_CH{10'(DD)}};
        m_phase = {N_CH{13'(DP)}};
    endtask
    // PLL model: lock is lost while pll_rst is high and returns LOCK_DLY cycles after it falls
    initial forever begin
        @(posedge clk);
        #1;
        if (rst || pll_rst) mcnt = 0;
        else if (mcnt < LOCK_DLY) mcnt++;
        pll_lock = mdl_on && !glitch && mcnt >= LOCK_DLY;
    end
    initial begin : mon_done
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && cfg_done) begin
                if (sb.size() == 0) chk("done_unexpected", 128'(1), 128'(0));
                else begin
                    e = sb.pop_front();
                    chk("done_status", 128'(cfg_status), 128'(e.st));
                    chk("done_odiv", 128'(dyn_odiv), 128'(e.od));
                    chk("done_duty", 128'(dyn_duty), 128'(e.du));
                    chk("done_phase", 128'(dyn_phase), 128'(e.ph));
                end
            end
        end
    end
    initial begin : mon_rst
        int hi, lo;
        hi = 0;
        lo = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hi = 0;
                lo = 0;
            end else if (pll_rst) begin
                if (hi == 0) gq.push_back(lo);
                hi++;
                lo = 0;
            end else begin
                if (hi != 0) pq.push_back(hi);
                hi = 0;
                lo++;
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
    task automatic req(input logic [2:0] ch, input logic [9:0] r, input logic [9:0] d,
                       input logic [12:0] p, input logic [1:0] st, input bit push);
        int n = 0;
        @(negedge clk);
        cfg_ch = ch; cfg_ratio = r; cfg_duty = d; cfg_phase = p; cfg_valid = 1;
        while (!cfg_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready", 128'(cfg_ready), 128'(1));
        if (int'(ch) < N_CH && r != 0) begin
            m_odiv[int'(ch)*10 +: 10]  = r;
            m_duty[int'(ch)*10 +: 10]  = d;
            m_phase[int'(ch)*13 +: 13] = p;
        end
        if (push) sb.push_back('{st, m_odiv, m_duty, m_phase});
        @(posedge clk);
        #1;
        cfg_valid = 0;
        cfg_ch = 3'($urandom); cfg_ratio = 10'($urandom); cfg_duty = 10'($urandom); cfg_phase = 13'($urandom);
    endtask
    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 128'(sb.size()), 128'(0));
    endtask
    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while ((busy || !locked) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 128'({busy, locked}), 128'(2'b01));
    endtask
    initial begin
        int n;
        bit seen, minlk;
        tv[0] = '{3'd2, 10'd12, 10'd12, 13'd40, 1'b1, 2'd0, 1};
        tv[1] = '{3'd5, 10'd20, 10'd3, 13'd7, 1'b1, 2'd1, 0};
        tv[2] = '{3'd1, 10'd0, 10'd9, 13'd9, 1'b1, 2'd1, 0};
        tv[3] = '{3'd0, 10'd100, 10'd50, 13'd4000, 1'b1, 2'd0, 1};
        tv[4] = '{3'd4, 10'd1023, 10'd1, 13'd8191, 1'b1, 2'd0, 1};
        tv[5] = '{3'd7, 10'd5, 10'd5, 13'd5, 1'b1, 2'd1, 0};
        tv[6] = '{3'd3, 10'd33, 10'd17, 13'd123, 1'b0, 2'd2, 4};
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pll_rst", 128'(pll_rst), 128'(1));
        chk("rst_ready", 128'(cfg_ready), 128'(0));
        chk("rst_done", 128'({cfg_done, cfg_status}), 128'(0));
        chk("rst_flags", 128'({locked, lock_lost, busy}), 128'(3'b001));
        chk("rst_odiv", 128'(dyn_odiv), 128'(m_odiv));
        chk("rst_duty", 128'(dyn_duty), 128'(m_duty));
        chk("rst_phase", 128'(dyn_phase), 128'(m_phase));
        @(posedge clk);
        #1;
        rst = 0;
        n = 0;
        while (!pll_lock && n < 1000) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!locked && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("pwr_lock_latency", 128'(n), 128'(LOCK_FILT + 2));
        wait_idle("pwr_idle", 500);
        chk("pwr_pulses", 128'(pq.size()), 128'(1));
        chk("pwr_pulse_len", 128'(pq[0]), 128'(RST_CYCLES));
        for (int i = 0; i < NV; i++) begin
            mdl_on = tv[i].lk;
            pq.delete();
            gq.delete();
            req(tv[i].ch, tv[i].r, tv[i].d, tv[i].p, tv[i].st, 1);
            if (tv[i].st == 2'd1) begin
                @(negedge clk);
                chk("bad_done_next", 128'({cfg_done, cfg_status, pll_rst}), 128'(4'b1010));
            end
            wait_done("vec_done", 2000);
            @(negedge clk);
            chk("vec_pulses", 128'(pq.size()), 128'(tv[i].pulses));
            foreach (pq[j]) chk("vec_pulse_len", 128'(pq[j]), 128'(RST_CYCLES));
            for (int j = 1; j < gq.size(); j++) chk("vec_retry_gap", 128'(gq[j]), 128'(LOCK_TIMEOUT));
        end
        mdl_on = 1;
        wait_idle("relock_pre", 500);
        @(negedge clk);
        glitch = 1;
        repeat (5) @(negedge clk);
        glitch = 0;
        minlk = 1;
        repeat (20) @(negedge clk) minlk &= locked;
        chk("glitch5_locked", 128'({minlk, busy, lock_lost}), 128'(3'b100));
        pq.delete();
        glitch = 1;
        repeat (20) @(negedge clk);
        glitch = 0;
        chk("loss_flag", 128'({lock_lost, busy}), 128'(2'b11));
        req(3'd1, 10'd77, 10'd7, 13'd700, 2'd0, 1);
        wait_done("held_req_done", 2000);
        wait_idle("relock_idle", 500);
        chk("relock_pulses", 128'(pq.size()), 128'(2));
        chk("loss_sticky", 128'(lock_lost), 128'(1));
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        chk("loss_cleared", 128'(lock_lost), 128'(0));
        err_clr = 1;
        glitch = 1;
        seen = 0;
        repeat (40) @(negedge clk) seen |= lock_lost;
        glitch = 0;
        wait_idle("clr_loss_idle", 500);
        err_clr = 0;
        @(negedge clk);
        chk("clr_vs_loss_seen", 128'(seen), 128'(1));
        chk("clr_vs_loss_after", 128'(lock_lost), 128'(0));
        mdl_on = 0;
        req(3'd2, 10'd50, 10'd5, 13'd5, 2'd0, 0);
        repeat (RST_CYCLES + 20) @(negedge clk);
        chk("in_wait_lock", 128'({pll_rst, busy}), 128'(2'b01));
        #3;
        rst = 1;
        #1;
        m_reset();
        chk("midrst_flags", 128'({pll_rst, cfg_ready, busy, locked, lock_lost}), 128'(5'b10100));
        chk("midrst_odiv", 128'(dyn_odiv), 128'(m_odiv));
        chk("midrst_duty", 128'(dyn_duty), 128'(m_duty));
        chk("midrst_phase", 128'(dyn_phase), 128'(m_phase));
        @(posedge clk);
        #1;
        rst = 0;
        mdl_on = 1;
        wait_idle("midrst_relock", 1000);
        req(3'd0, 10'd9, 10'd9, 13'd9, 2'd0, 1);
        wait_done("post_rst_req", 2000);
        @(negedge clk);
        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
